painel_scroll_controller: RTL

- Sequencing controller for the 16-bit universal (load/rotate/hold) register that feeds the digital display panel.
- Latches a message and issues a one-cycle parallel load through the register's mode inputs ch0/ch1 and parallel data bus.
- Then issues timed one-cycle rotate commands at a programmable rate, for a fixed step count or continuously, with pause and abort.
- Sits between the panel's user/control logic and the register; it is the register's only driver of ch0, ch1 and the parallel data.

---
 rtl/painel_scroll_controller.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/painel_scroll_controller.sv
`default_nettype none
// ============================================================================
// Module      : painel_scroll_controller
// Description : Sequencing controller for the 16-bit universal (load/rotate/
//               hold) register feeding the digital display panel. Accepts a
//               message, issues a one-cycle parallel load, then issues timed
//               one-cycle rotate commands at a programmable rate, either for
//               a fixed number of steps or continuously. Supports pause
//               (freezes the rate prescaler) and abort (immediate return to
//               idle).
//
// Ports       : clk        - system clock, rising edge
//               rst_n      - synchronous active-low reset
//               start      - pulse, accept message and begin (IDLE only)
//               msg        - message, sampled with an accepted start
//               dir        - 0 rotate toward lower index, 1 toward higher
//               divisor    - rotate period = divisor+1 cycles
//               steps      - rotate steps per sequence, 0 = continuous
//               pause      - level, freezes scrolling while high in RUN
//               abort      - pulse, terminate a LOAD/RUN sequence
//               ch0, ch1   - register mode bits ({ch1,ch0})
//               cadeia_out - register parallel data bus
//               busy       - sequence in progress (LOAD/RUN)
//               done       - one-cycle pulse on normal completion
//               step_cnt   - rotate steps issued in current/last sequence
//
// Revision    : 1.0 - initial release
// ============================================================================
module painel_scroll_controller #(
   parameter int DATA_W = 16,
   parameter int DIV_W  = 16,
   parameter int STEP_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] msg,
   input  logic              dir,
   input  logic [DIV_W-1:0]  divisor,
   input  logic [STEP_W-1:0] steps,
   input  logic              pause,
   input  logic              abort,
   output logic              ch0,
   output logic              ch1,
   output logic [DATA_W-1:0] cadeia_out,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] step_cnt
);

   // Register mode encoding {ch1,ch0}
   localparam logic [1:0] c_MODE_HOLD   = 2'b00;
   localparam logic [1:0] c_MODE_ROT_LO = 2'b01;
   localparam logic [1:0] c_MODE_ROT_HI = 2'b10;
   localparam logic [1:0] c_MODE_LOAD   = 2'b11;

   localparam logic [DIV_W-1:0]  c_DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [STEP_W-1:0] c_STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t              r_state;
   logic [1:0]          r_ch;
   logic [DATA_W-1:0]   r_cadeia;
   logic                r_busy;
   logic                r_done;
   logic [STEP_W-1:0]   r_step;
   logic [DIV_W-1:0]    r_presc;
   logic                r_dir;
   logic [DIV_W-1:0]    r_div;
   logic [STEP_W-1:0]   r_steps;

   // ------------------------------------------------------------------------
   // Next-state values
   // ------------------------------------------------------------------------
   state_t              w_state_nxt;
   logic [1:0]          w_ch_nxt;
   logic [DATA_W-1:0]   w_cadeia_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic [STEP_W-1:0]   w_step_nxt;
   logic [DIV_W-1:0]    w_presc_nxt;
   logic                w_dir_nxt;
   logic [DIV_W-1:0]    w_div_nxt;
   logic [STEP_W-1:0]   w_steps_nxt;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   logic [1:0]          w_shift_code;
   logic                w_tick;
   logic [DIV_W-1:0]    w_presc_adv;
   logic [1:0]          w_ch_adv;
   logic                w_shifting;
   logic [STEP_W-1:0]   w_step_adv;
   logic                w_last;

   assign w_shift_code = r_dir ? c_MODE_ROT_HI : c_MODE_ROT_LO;

   // r_presc counts counting edges since LOAD or since the last shift; the
   // (divisor+1)-th such edge schedules a rotate for the following cycle.
   // Because outputs are registered, a shift is decided one edge ahead of the
   // cycle in which it appears on ch0/ch1.
   assign w_tick      = (r_presc == r_div);
   assign w_presc_adv = w_tick ? '0 : (r_presc + c_DIV_ONE);
   assign w_ch_adv    = w_tick ? w_shift_code : c_MODE_HOLD;

   // A rotate command is currently on the bus (only ever in RUN).
   assign w_shifting = (r_state == S_RUN) && (r_ch[0] ^ r_ch[1]);
   assign w_step_adv = w_shifting ? (r_step + c_STEP_ONE) : r_step;
   assign w_last     = w_shifting && (r_steps != '0) && (w_step_adv == r_steps);

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_ch_nxt     = c_MODE_HOLD;
      w_cadeia_nxt = r_cadeia;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
      w_step_nxt   = r_step;
      w_presc_nxt  = r_presc;
      w_dir_nxt    = r_dir;
      w_div_nxt    = r_div;
      w_steps_nxt  = r_steps;

      case (r_state)
         S_IDLE: begin
            // abort outranks start: a coincident pair is ignored
            if (start && !abort) begin
               w_state_nxt  = S_LOAD;
               w_ch_nxt     = c_MODE_LOAD;
               w_cadeia_nxt = msg;
               w_busy_nxt   = 1'b1;
               w_step_nxt   = '0;
               w_presc_nxt  = '0;
               w_dir_nxt    = dir;
               w_div_nxt    = divisor;
               w_steps_nxt  = steps;
            end
         end

         S_LOAD: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               // The LOAD cycle always counts toward the first period, so a
               // zero divisor rotates in the very first RUN cycle.
               w_state_nxt = S_RUN;
               w_busy_nxt  = 1'b1;
               w_presc_nxt = w_presc_adv;
               w_ch_nxt    = w_ch_adv;
            end
         end

         S_RUN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_step_nxt = w_step_adv;
               if (w_last) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_busy_nxt = 1'b1;
                  // A paused cycle does not count, which defers a due shift
                  // until pause drops.
                  if (!pause) begin
                     w_presc_nxt = w_presc_adv;
                     w_ch_nxt    = w_ch_adv;
                  end
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_ch     <= c_MODE_HOLD;
         r_cadeia <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_step   <= '0;
         r_presc  <= '0;
         r_dir    <= 1'b0;
         r_div    <= '0;
         r_steps  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_ch     <= w_ch_nxt;
         r_cadeia <= w_cadeia_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_step   <= w_step_nxt;
         r_presc  <= w_presc_nxt;
         r_dir    <= w_dir_nxt;
         r_div    <= w_div_nxt;
         r_steps  <= w_steps_nxt;
      end
   end

   assign ch0        = r_ch[0];
   assign ch1        = r_ch[1];
   assign cadeia_out = r_cadeia;
   assign busy       = r_busy;
   assign done       = r_done;
   assign step_cnt   = r_step;

endmodule
`default_nettype wire
